imuldiv_int_div_iterative: RTL
==============================

# imuldiv_int_div_iterative

Iterative 32-bit integer divider that is the responder on the muldiv val/rdy request/response protocol. It accepts one divide request at a time and produces quotient and remainder together after a fixed 32-step restoring shift-subtract sequence. It supports signed and unsigned operation. It slots in wherever the combined iterative muldiv unit is used for division-only paths, and is driven by the same source/sink harness style.

## Interface
- No parameters; datapath fixed at 32-bit operands, 64-bit result.
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- divreq_msg_fn  input  1  0 = unsigned (divu/remu), 1 = signed (div/rem).
- divreq_msg_a  input  32  dividend.
- divreq_msg_b  input  32  divisor.
- divreq_val  input  1  request valid.
- divreq_rdy  output  1  ready to accept a request.
- divresp_msg_result  output  64  {remainder[63:32], quotient[31:0]}.
- divresp_val  output  1  response valid.
- divresp_rdy  input  1  sink ready.

## Operation
- FSM states:
  - IDLE: divreq_rdy=1. On divreq_val&&divreq_rdy, latch the operands and go to CALC with counter=32.
  - CALC: perform one iteration per cycle and decrement the counter. After the iteration taken at counter=1, go to DONE.
  - DONE: divresp_val=1. On divresp_val&&divresp_rdy, go to IDLE.
- On accept, latch:
  - sign_a = fn & a[31] and sign_b = fn & b[31].
  - Magnitudes |a| and |b|: two's-complement negate when the sign is set.
  - Load 65-bit register R = {33'b0, |a|} and divisor register D = |b|.
  - Latch the fn, a and b==0 flags for the divide-by-zero path.
- Each CALC iteration:
  - R' = R<<1.
  - T = R'[64:32] - {1'b0, D}, computed 33 bits wide.
  - If T[32]==0 (non-negative): R = {T[31:0], R'[31:1], 1'b1}.
  - Else: R = R'.
- Final raw quotient is R[31:0]; final raw remainder is R[63:32].
- Sign fix-up, applied combinationally on the output in DONE:
  - quotient is negated iff sign_a ^ sign_b.
  - remainder is negated iff sign_a (remainder takes the dividend's sign).
- Divide by zero (b==0), both signed and unsigned:
  - result = {a, 32'hFFFF_FFFF}.
  - The FSM still spends 32 CALC cycles, so latency is constant.
- Signed overflow (0x80000000 / 0xFFFFFFFF): result = {32'h0, 32'h8000_0000}. This falls out of the datapath naturally and needs no special case.
- Only one operation is in flight; no request is accepted outside IDLE.
- Input operands need not be held stable after the accept edge.

## Timing
- Reset: state=IDLE, counter=0, R=0, D=0.
  - Outputs after reset: divreq_rdy=1, divresp_val=0, divresp_msg_result=0.
  - While in IDLE, divresp_msg_result is driven to 0.
- Latency: accept at edge N; divresp_val rises after edge N+32, i.e. it is visible in cycle N+32 through N+33.
  - With divresp_rdy held high, the response handshake completes at edge N+33.
  - Total is 33 cycles from the accept edge to the response handshake edge.
- Backpressure: divresp_val and divresp_msg_result hold stable in DONE until divresp_rdy=1. There is no timeout.
- After the response handshake, IDLE asserts rdy in the next cycle.
  - Back-to-back requests are therefore spaced 34 edges apart.
  - There is no same-cycle response/accept overlap.
- divreq_rdy and divresp_val are decoded from registered state only, never combinationally from inputs.
- divreq_val asserted during CALC or DONE is ignored and not latched.
- Reset asserted mid-CALC or mid-DONE:
  - The in-flight operation is abandoned with no response.
  - IDLE and the reset output values hold from the next edge.
- Simultaneous reset and divreq_val: reset wins and the request is not accepted.

## Test plan
- Unsigned basic: fn=0, a=0x00000014, b=0x00000003.
  - Required: result=0x00000002_00000006, val rises 32 cycles after the accept edge, rdy low throughout.
- Signed mixed signs: fn=1, a=0xFFFFFFEC (-20), b=0x00000003.
  - Required: quotient=0xFFFFFFFA (-6), remainder=0xFFFFFFFE (-2).
  - Then a=0x00000014, b=0xFFFFFFFD: required quotient=0xFFFFFFFA, remainder=0x00000002.
- Corners:
  - b=0, a=0x12345678, both fn values: required result=0x12345678_FFFFFFFF after 32 cycles.
  - Signed 0x80000000 / 0xFFFFFFFF: required result=0x00000000_80000000.
  - Unsigned 0xFFFFFFFF / 0x00000001: required result=0x00000000_FFFFFFFF.
- Backpressure: hold divresp_rdy=0 for 10 cycles after val rises.
  - Required: val and result stable throughout, handshake on the first rdy=1 edge, rdy returns the next cycle.
  - A divreq_val pulse during CALC must be ignored.
- Reset mid-operation: assert reset at CALC iteration 15.
  - Required: divresp_val never rises, rdy=1 the cycle after reset deasserts.
  - A fresh request (0x64 divu 0x7) then returns 0x00000002_0000000E.
- Random sweep: 1000 random {fn,a,b} pairs with divresp_rdy randomly toggled.
  - Required: every result matches the reference model, including the b==0 and overflow rules.
  - Each handshake-to-handshake latency is at least 33 cycles, and exactly 33 when rdy is held high.

Source files
------------

// File: rtl/imuldiv_int_div_iterative_if.sv
// Request/response bundle for the iterative divider.
// The request side carries the function select and both operands under val/rdy.
// The response side carries {remainder, quotient} under val/rdy.
interface imuldiv_int_div_iterative_if;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a;
    logic [31:0] divreq_msg_b;
    logic        divreq_val;
    logic        divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val;
    logic        divresp_rdy;

    // Source/sink harness side: issues requests and consumes responses.
    modport master (
        output divreq_msg_fn,
        output divreq_msg_a,
        output divreq_msg_b,
        output divreq_val,
        input  divreq_rdy,
        input  divresp_msg_result,
        input  divresp_val,
        output divresp_rdy
    );

    // Divider side: accepts requests and produces responses.
    modport slave (
        input  divreq_msg_fn,
        input  divreq_msg_a,
        input  divreq_msg_b,
        input  divreq_val,
        output divreq_rdy,
        output divresp_msg_result,
        output divresp_val,
        input  divresp_rdy
    );
endinterface

// File: rtl/imuldiv_int_div_iterative.sv
// Iterative 32-bit restoring divider (signed/unsigned), one op in flight.
// Operation: accept in IDLE, run 32 shift-subtract steps in CALC, then hold
// {remainder, quotient} in DONE until the sink takes it.
// Signs are stripped on accept and restored combinationally on the output.
module imuldiv_int_div_iterative (
    input  logic                              clk,
    input  logic                              reset,
    imuldiv_int_div_iterative_if.slave        div_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    // Upper half is the partial remainder, lower half shifts the dividend out
    // and the quotient in. The 65th bit of the textbook form is always zero
    // (the partial remainder stays below the divisor) and is not stored.
    logic [63:0] rem_quot_q;
    logic [31:0] divisor_q;
    logic [31:0] dividend_q;
    logic        sign_a_q;
    logic        sign_b_q;
    logic        div_zero_q;
    logic        req_rdy_q;
    logic        resp_val_q;

    logic signed [31:0] req_a_s;
    logic signed [31:0] req_b_s;
    logic               sign_a_d;
    logic               sign_b_d;
    logic [32:0]        trial_d;
    logic [63:0]        step_d;
    logic [31:0]        quot_raw;
    logic [31:0]        rem_raw;
    logic [63:0]        result_d;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return (~x) + 32'd1;
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] x, input logic en);
        return en ? neg32(x) : x;
    endfunction

    assign req_a_s  = div_if.divreq_msg_a;
    assign req_b_s  = div_if.divreq_msg_b;
    assign sign_a_d = div_if.divreq_msg_fn & (req_a_s < 0);
    assign sign_b_d = div_if.divreq_msg_fn & (req_b_s < 0);

    // Trial subtraction of the divisor from the shifted partial remainder.
    // rem_quot_q[63:31] is bits [64:32] of the register shifted left by one.
    assign trial_d = rem_quot_q[63:31] - {1'b0, divisor_q};
    assign step_d  = trial_d[32] ? {rem_quot_q[62:0], 1'b0}
                                 : {trial_d[31:0], rem_quot_q[30:0], 1'b1};

    assign quot_raw = rem_quot_q[31:0];
    assign rem_raw  = rem_quot_q[63:32];

    // Output fix-up: divide-by-zero override, else restore signs; zero when not DONE.
    always_comb begin
        result_d = '0;
        if (state_q == DONE) begin
            if (div_zero_q) begin
                result_d = {dividend_q, 32'hFFFF_FFFF};
            end else begin
                result_d = {cond_neg32(rem_raw, sign_a_q),
                            cond_neg32(quot_raw, sign_a_q ^ sign_b_q)};
            end
        end
    end

    assign div_if.divreq_rdy         = req_rdy_q;
    assign div_if.divresp_val        = resp_val_q;
    assign div_if.divresp_msg_result = result_d;

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_quot_q <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            req_rdy_q  <= 1'b1;
            resp_val_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_if.divreq_val && req_rdy_q) begin
                        state_q    <= CALC;
                        cnt_q      <= 6'd32;
                        rem_quot_q <= {32'd0, cond_neg32(div_if.divreq_msg_a, sign_a_d)};
                        divisor_q  <= cond_neg32(div_if.divreq_msg_b, sign_b_d);
                        dividend_q <= div_if.divreq_msg_a;
                        sign_a_q   <= sign_a_d;
                        sign_b_q   <= sign_b_d;
                        div_zero_q <= (div_if.divreq_msg_b == 32'd0);
                        req_rdy_q  <= 1'b0;
                    end
                end
                CALC: begin
                    // Divide-by-zero runs the full sequence too, keeping latency fixed.
                    rem_quot_q <= step_d;
                    cnt_q      <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_q    <= DONE;
                        resp_val_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (div_if.divresp_rdy) begin
                        state_q    <= IDLE;
                        resp_val_q <= 1'b0;
                        req_rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    req_rdy_q  <= 1'b1;
                    resp_val_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
